shift_pattern_detector: RTL and testbench
=========================================

Name: shift_pattern_detector

Overview:
- Downstream consumer of the 4-stage serial shift chain; sees the same serial bit stream and the same slow shift instants.
- Keeps its own 4-bit history window and flags when the window equals a programmable 4-bit pattern.
- Counts matches in 2-digit BCD (00..99, saturating) for the 7-segment display path.
- Stretches each match into a visible LED pulse measured in shift ticks.
- Runs entirely on the 50 MHz clock; the slow shift rate arrives as a one-cycle enable, not as a derived clock.

Parameters:
- PATTERN, 4'b1011, target sequence; PATTERN[3] is the oldest bit, PATTERN[0] the newest.
- OVERLAP, 1, 1 = overlapping detection; 0 = window fill restarts after each match.
- HOLD_TICKS, 3, number of shift ticks match_led stays high after a match (1..15).

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset_n  input  1  asynchronous, active-low reset.
- shift_tick  input  1  one-clk-wide pulse at each shift instant.
- din  input  1  serial bit, sampled only when shift_tick=1.
- clr  input  1  synchronous clear of history, fill, counters and stretch.
- window  output  4  current history; bit0 is the newest sample.
- match  output  1  one-clk pulse per detected match.
- match_led  output  1  stretched match indicator.
- cnt_ones  output  4  BCD ones digit of the match count.
- cnt_tens  output  4  BCD tens digit of the match count.
- cnt_sat  output  1  high while the count is held at 99.

Behaviour:
- Reset (reset_n=0, async): window=0, fill=0, match=0, match_led=0, hold counter=0, cnt=00, cnt_sat=0. All outputs are registered.
- Sampling: on a clk edge with shift_tick=1 and clr=0:
  - window <= {window[2:0], din}.
  - fill (0..4) increments, saturating at 4.
- Cycles without shift_tick leave window, fill and match_led timing unchanged.
- Match condition: evaluated on the post-shift values, i.e. next_fill==4 and next_window==PATTERN, with both computed combinationally from the shift.
  - match is high for exactly the one clk following the sampling edge (latency 1 clk from the tick).
  - Leading zeros from reset never match, because fill<4.
- OVERLAP=0: on a match, fill <= 0 while window still shifts. The next match requires 4 fresh samples.
- OVERLAP=1: fill stays at 4, so consecutive matches are possible (e.g. PATTERN 1111 matches on every tick).
- Counter: increments on each match in BCD.
  - ones 9 -> 0 with a tens carry.
  - 99 holds at 99 and cnt_sat=1; further matches still pulse match and match_led.
- Stretch: a match loads hold <= HOLD_TICKS and sets match_led=1 in the same clk as match.
  - Each later shift_tick with no new match decrements hold; match_led drops in the clk after hold reaches 0.
  - A new match while stretching reloads HOLD_TICKS.
- clr=1: same clearing as reset on the next edge (window, fill, cnt, hold, match_led, match go to 0).
  - clr has priority over a simultaneous shift_tick; that sample is discarded.
- Reset mid-stretch or mid-count: everything returns to reset values immediately; no pending match is emitted after release.
- shift_tick held high for several clks: each clk counts as a separate sample. Upstream must guarantee single-cycle ticks.

Test Plan:
- Reset, then shift 1,0,1,1 (default PATTERN) -> match pulses once, 1 clk after the 4th tick; window=4'b1011; cnt=01; match_led high for 3 further ticks, then low.
- OVERLAP=1 with stream 1,0,1,1,0,1,1 -> two matches (ticks 4 and 7); cnt=02. Same stream with OVERLAP=0 -> one match; cnt=01.
- PATTERN=4'b0000, 3 ticks of din=0 after reset -> no match (fill<4); 4th zero -> match.
- Force 100 matches (PATTERN 1111, OVERLAP=1, din=1 held) -> cnt goes 98, 99, 99; cnt_sat=1 at the 99th match; match still pulses at the 100th.
- shift_tick and clr asserted in the same clk while window=4'b1101 -> window=0, cnt=00, no match on the next clk.
- reset_n dropped asynchronously mid-stretch (match_led=1, cnt=05) -> all outputs 0 before the next clk edge; after release, 3 ticks of din=1 -> no match.

Source files
------------

// File: rtl/shift_pattern_detector.sv
// Serial pattern detector on the shared shift stream: 4-bit history window,
// programmable match, saturating 2-digit BCD match counter and LED stretch.
module shift_pattern_detector #(
  parameter logic [3:0]  PATTERN    = 4'b1011,
  parameter bit          OVERLAP    = 1'b1,
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       shift_tick,
  input  logic       din,
  input  logic       clr,
  output logic [3:0] window,
  output logic       match,
  output logic       match_led,
  output logic [3:0] cnt_ones,
  output logic [3:0] cnt_tens,
  output logic       cnt_sat
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_TICKS);

  logic [2:0] fill;
  logic [3:0] hold;
  logic [3:0] next_window;
  logic [2:0] next_fill;
  logic       hit;

  // Match is decided on the post-shift window/fill so it registers one clk after the tick.
  always_comb begin
    next_window = {window[2:0], din};
    next_fill   = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    hit         = shift_tick && (next_fill == 3'd4) && (next_window == PATTERN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window <= '0;
      fill   <= '0;
      match  <= 1'b0;
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
      match  <= 1'b0;
    end else begin
      match <= hit;
      if (shift_tick) begin
        window <= next_window;
        fill   <= (hit && !OVERLAP) ? 3'd0 : next_fill;
      end
    end
  end

  // LED falls on the clk after hold has counted down to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      match_led <= 1'b0;
    end else if (clr) begin
      hold      <= '0;
      match_led <= 1'b0;
    end else if (hit) begin
      hold      <= HOLD_LOAD;
      match_led <= 1'b1;
    end else begin
      if (shift_tick && (hold != 4'd0)) hold <= hold - 4'd1;
      if (match_led && (hold == 4'd0)) match_led <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_ones <= '0;
      cnt_tens <= '0;
      cnt_sat  <= 1'b0;
    end else if (clr) begin
      cnt_ones <= '0;
      cnt_tens <= '0;
      cnt_sat  <= 1'b0;
    end else if (hit && !cnt_sat) begin
      if (cnt_ones == 4'd9) begin
        cnt_ones <= '0;
        cnt_tens <= cnt_tens + 4'd1;
      end else begin
        cnt_ones <= cnt_ones + 4'd1;
      end
      if ((cnt_tens == 4'd9) && (cnt_ones == 4'd8)) cnt_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_pattern_detector.sv
// Bench for shift_pattern_detector: four parameter variants share one stimulus
// stream and are checked every cycle against a behavioural model plus literals.
module tb_shift_pattern_detector;

  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam logic [3:0] PAT [N] = '{4'b1011, 4'b1011, 4'b0000, 4'b1111};
  localparam bit         OVL [N] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic shift_tick = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  logic [3:0] win_d  [N];
  logic       match_d[N];
  logic       led_d  [N];
  logic [3:0] ones_d [N];
  logic [3:0] tens_d [N];
  logic       sat_d  [N];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  shift_pattern_detector #(.PATTERN(4'b1011), .OVERLAP(1'b1), .HOLD_TICKS(HOLD)) u0 (
    .clk(clk), .reset_n(reset_n), .shift_tick(shift_tick), .din(din), .clr(clr),
    .window(win_d[0]), .match(match_d[0]), .match_led(led_d[0]),
    .cnt_ones(ones_d[0]), .cnt_tens(tens_d[0]), .cnt_sat(sat_d[0]));
  shift_pattern_detector #(.PATTERN(4'b1011), .OVERLAP(1'b0), .HOLD_TICKS(HOLD)) u1 (
    .clk(clk), .reset_n(reset_n), .shift_tick(shift_tick), .din(din), .clr(clr),
    .window(win_d[1]), .match(match_d[1]), .match_led(led_d[1]),
    .cnt_ones(ones_d[1]), .cnt_tens(tens_d[1]), .cnt_sat(sat_d[1]));
  shift_pattern_detector #(.PATTERN(4'b0000), .OVERLAP(1'b1), .HOLD_TICKS(HOLD)) u2 (
    .clk(clk), .reset_n(reset_n), .shift_tick(shift_tick), .din(din), .clr(clr),
    .window(win_d[2]), .match(match_d[2]), .match_led(led_d[2]),
    .cnt_ones(ones_d[2]), .cnt_tens(tens_d[2]), .cnt_sat(sat_d[2]));
  shift_pattern_detector #(.PATTERN(4'b1111), .OVERLAP(1'b1), .HOLD_TICKS(HOLD)) u3 (
    .clk(clk), .reset_n(reset_n), .shift_tick(shift_tick), .din(din), .clr(clr),
    .window(win_d[3]), .match(match_d[3]), .match_led(led_d[3]),
    .cnt_ones(ones_d[3]), .cnt_tens(tens_d[3]), .cnt_sat(sat_d[3]));

  // Model: last four bits, samples since (re)start, match count as an integer,
  // and shift ticks elapsed since the most recent match.
  logic [3:0] win_m  [N];
  int         fill_m [N];
  int         cnt_m  [N];
  int         since_m[N];
  bit         seen_m [N];
  bit         match_m[N];
  bit         led_m  [N];

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < N; i++) begin
      if (!reset_n || clr) begin
        win_m[i] = '0; fill_m[i] = 0; cnt_m[i] = 0; since_m[i] = 0;
        seen_m[i] = 0; match_m[i] = 0; led_m[i] = 0;
      end else begin : step
        bit hit;
        hit = 0;
        if (shift_tick) begin
          win_m[i]  = {win_m[i][2:0], din};
          fill_m[i] = (fill_m[i] < 4) ? fill_m[i] + 1 : 4;
          hit = (fill_m[i] == 4) && (win_m[i] == PAT[i]);
          if (hit && !OVL[i]) fill_m[i] = 0;
        end
        led_m[i] = hit || (seen_m[i] && since_m[i] < HOLD);
        if (hit) begin
          seen_m[i] = 1; since_m[i] = 0;
          if (cnt_m[i] < 99) cnt_m[i] = cnt_m[i] + 1;
        end else if (shift_tick && since_m[i] < 100) begin
          since_m[i] = since_m[i] + 1;
        end
        match_m[i] = hit;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("window[%0d]", i), int'(win_d[i]),  int'(win_m[i]));
      chk($sformatf("match[%0d]", i),  int'(match_d[i]), int'(match_m[i]));
      chk($sformatf("led[%0d]", i),    int'(led_d[i]),   int'(led_m[i]));
      chk($sformatf("ones[%0d]", i),   int'(ones_d[i]),  cnt_m[i] % 10);
      chk($sformatf("tens[%0d]", i),   int'(tens_d[i]),  cnt_m[i] / 10);
      chk($sformatf("sat[%0d]", i),    int'(sat_d[i]),   (cnt_m[i] == 99) ? 1 : 0);
    end
  end

  task automatic tick(input logic b);
    @(negedge clk); shift_tick = 1'b1; din = b;
    @(negedge clk); shift_tick = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("lit_reset_window", int'(win_d[0]), 0);
    chk("lit_reset_led",    int'(led_d[0]), 0);
    chk("lit_reset_cnt",    int'({tens_d[0], ones_d[0]}), 0);
    reset_n = 1'b1;

    // 1,0,1,1 then 0,1,1: overlap variant matches twice, non-overlap once
    tick(1); tick(0); tick(1);
    chk("lit_no_match_3rd", int'(match_d[0]), 0);
    tick(1);
    chk("lit_match_4th",    int'(match_d[0]), 1);
    chk("lit_match_4th_n",  int'(match_d[1]), 1);
    chk("lit_window_1011",  int'(win_d[0]), 11);
    chk("lit_cnt_01",       int'(ones_d[0]), 1);
    chk("lit_led_on",       int'(led_d[0]), 1);
    @(negedge clk);
    chk("lit_match_1clk",   int'(match_d[0]), 0);
    tick(0); tick(1); tick(1);
    chk("lit_match_7th",    int'(match_d[0]), 1);
    chk("lit_nomatch_7th_n", int'(match_d[1]), 0);
    chk("lit_cnt_02",       int'(ones_d[0]), 2);
    chk("lit_cnt_01_n",     int'(ones_d[1]), 1);
    tick(0); tick(0); tick(0);
    chk("lit_led_after_3", int'(led_d[0]), 1);
    @(negedge clk);
    chk("lit_led_off",     int'(led_d[0]), 0);

    // all-zero pattern needs a full window first
    do_clr();
    tick(0); tick(0); tick(0);
    chk("lit_zero_no_match", int'(match_d[2]), 0);
    tick(0);
    chk("lit_zero_match",    int'(match_d[2]), 1);

    // clr wins over a simultaneous tick
    do_clr();
    tick(1); tick(1); tick(0); tick(1);
    chk("lit_window_1101", int'(win_d[0]), 13);
    @(negedge clk); shift_tick = 1'b1; clr = 1'b1; din = 1'b1;
    @(negedge clk); shift_tick = 1'b0; clr = 1'b0;
    chk("lit_clr_window", int'(win_d[0]), 0);
    chk("lit_clr_cnt",    int'({tens_d[0], ones_d[0]}), 0);
    chk("lit_clr_match",  int'(match_d[0]), 0);
    @(negedge clk);
    chk("lit_clr_match2", int'(match_d[0]), 0);

    // saturation: 1111 with din held at 1
    do_clr();
    for (int k = 1; k <= 103; k++) begin
      tick(1);
      if (k == 101) begin
        chk("lit_cnt_98",  int'(tens_d[3]) * 10 + int'(ones_d[3]), 98);
        chk("lit_sat_98",  int'(sat_d[3]), 0);
      end
      if (k == 102) begin
        chk("lit_cnt_99",  int'(tens_d[3]) * 10 + int'(ones_d[3]), 99);
        chk("lit_sat_99",  int'(sat_d[3]), 1);
      end
      if (k == 103) begin
        chk("lit_cnt_hold", int'(tens_d[3]) * 10 + int'(ones_d[3]), 99);
        chk("lit_match_100", int'(match_d[3]), 1);
        chk("lit_led_100",   int'(led_d[3]), 1);
      end
    end

    // async reset mid-stretch with count at 05
    do_clr();
    tick(1); tick(0); tick(1); tick(1);
    repeat (4) begin tick(0); tick(1); tick(1); end
    chk("lit_cnt_05",      int'(ones_d[0]), 5);
    chk("lit_led_stretch", int'(led_d[0]), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("lit_arst_window", int'(win_d[0]), 0);
    chk("lit_arst_led",    int'(led_d[0]), 0);
    chk("lit_arst_match",  int'(match_d[0]), 0);
    chk("lit_arst_cnt",    int'({tens_d[0], ones_d[0]}), 0);
    @(negedge clk); reset_n = 1'b1;
    tick(1); tick(1); tick(1);
    chk("lit_post_rst_match", int'(match_d[3]), 0);
    chk("lit_post_rst_cnt",   int'(ones_d[3]), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
